// File: rtl/ym2413_audio_out_pkg.sv
// ym2413_audio_out_pkg
// Shared widths and the mixer FSM state type for the YM2413 audio output
// stage (ym2413_audio_out) and its delta-sigma DAC (ym2413_ds_dac).
package ym2413_audio_out_pkg;

    localparam int FM_W     = 11;  // FM sample / external audio width
    localparam int MIX_W    = 12;  // mixed PCM width
    localparam int PROD_W   = 15;  // sample * fm_vol product width
    localparam int VOL_W    = 4;   // FM gain width (n/16)
    localparam int DS_ACC_W = 12;  // delta-sigma accumulator width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_SUM,
        ST_FILT,
        ST_OUT
    } state_t;

endpackage

// File: rtl/ym2413_ds_dac.sv
// ym2413_ds_dac
// First-order carry-out delta-sigma modulator with a clock-enable divider.
// Every DS_DIV clk cycles the 12-bit accumulator adds mix_out; the carry out
// of that add becomes the DAC bit and is held until the next update, so the
// ones density of dac_out is mix_out/4096.
//
// Parameters:
//   DS_DIV  update period in clk cycles (1..255)
// Ports:
//   clk      system clock
//   res_n    synchronous active-low reset
//   mix_out  12-bit unsigned PCM level to modulate
//   dac_out  1-bit delta-sigma stream
module ym2413_ds_dac
    import ym2413_audio_out_pkg::*;
#(
    parameter int DS_DIV = 1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [MIX_W-1:0] mix_out,
    output logic             dac_out
);

    localparam int CNT_W = 8;

    if (DS_DIV < 1 || DS_DIV > 255) begin : g_ds_div_chk
        $error("ym2413_ds_dac: DS_DIV must be 1..255");
    end

    logic [CNT_W-1:0]    div_cnt;
    logic                ds_ce;
    logic [DS_ACC_W-1:0] dacc;
    logic [DS_ACC_W:0]   ds_sum;

    assign ds_ce  = (div_cnt == CNT_W'(DS_DIV - 1));
    assign ds_sum = (DS_ACC_W + 1)'(dacc) + (DS_ACC_W + 1)'(mix_out);

    always_ff @(posedge clk) begin
        if (!res_n) begin
            div_cnt <= '0;
            dacc    <= '0;
            dac_out <= 1'b0;
        end else begin
            if (ds_ce) begin
                div_cnt <= '0;
                dacc    <= ds_sum[DS_ACC_W-1:0];
                dac_out <= ds_sum[DS_ACC_W];
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ym2413_audio_out.sv
// ym2413_audio_out
// Output stage behind the YM2413 synthesis core. Each accepted strobe latches
// the FM sample, external audio and FM gain, multiplies sample*fm_vol with a
// 4-cycle shift-add, scales by 1/16, adds the external audio and (optionally)
// runs the mix through a first-order IIR low-pass before publishing it on
// mix_out. mix_out also drives a delta-sigma 1-bit DAC.
//
// Build option:
//   YM2413_AUDIO_OUT_FILTER_EN  defined   -> IIR stage present, latency 7
//                               undefined -> no IIR, latency 6, FILT_K unused
// Parameters:
//   FILT_K  IIR shift, pole = 1-2^-FILT_K (1..4)
//   DS_DIV  delta-sigma update period in clk cycles (1..255)
// Ports:
//   clk          system clock
//   res_n        synchronous active-low reset
//   sample_in    11-bit unsigned FM sample
//   sample_stb   one-cycle pulse, sample_in/ext_in valid
//   ext_in       11-bit unsigned external audio
//   fm_vol       FM gain n/16
//   mix_out      12-bit unsigned mix
//   mix_vld      one-cycle pulse when mix_out updates
//   sample_drop  one-cycle pulse, strobe arrived while busy
//   dac_out      delta-sigma bitstream
module ym2413_audio_out
    import ym2413_audio_out_pkg::*;
#(
    parameter int FILT_K = 2,
    parameter int DS_DIV = 1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [FM_W-1:0]  sample_in,
    input  logic             sample_stb,
    input  logic [FM_W-1:0]  ext_in,
    input  logic [VOL_W-1:0] fm_vol,
    output logic [MIX_W-1:0] mix_out,
    output logic             mix_vld,
    output logic             sample_drop,
    output logic             dac_out
);

    if (FILT_K < 1 || FILT_K > 4) begin : g_filt_k_chk
        $error("ym2413_audio_out: FILT_K must be 1..4");
    end

    // 1/16 gain scaling followed by the external mix. 1919 + 2047 still fits
    // in 12 bits, so no saturation is required.
    function automatic logic [MIX_W-1:0] mix_sum(input logic [PROD_W-1:0] p,
                                                 input logic [FM_W-1:0]   e);
        return MIX_W'(p[PROD_W-1:VOL_W]) + MIX_W'(e);
    endfunction

    state_t             state;
    logic [1:0]         bit_cnt;
    logic [PROD_W-1:0]  mcand_p0;
    logic [VOL_W-1:0]   mplier_p0;
    logic [PROD_W-1:0]  prod_p0;
    logic [FM_W-1:0]    ext_p0;
    logic               busy;

`ifdef YM2413_AUDIO_OUT_FILTER_EN
    localparam int ACC_W = MIX_W + FILT_K;

    // acc holds y * 2^FILT_K; its steady state is mix * 2^FILT_K, so it
    // cannot wrap with ACC_W = MIX_W + FILT_K.
    function automatic logic [ACC_W-1:0] iir_step(input logic [ACC_W-1:0] a,
                                                  input logic [MIX_W-1:0] x);
        return a + ACC_W'(x) - (a >> FILT_K);
    endfunction

    logic [MIX_W-1:0] mix_p1;
    logic [ACC_W-1:0] acc_p2;
    logic [ACC_W-1:0] acc_nxt;

    assign acc_nxt = iir_step(acc_p2, mix_p1);
`endif

    // OUT is the last busy cycle but already able to accept a new strobe,
    // which gives a strobe-to-strobe spacing equal to the latency.
    assign busy = (state != ST_IDLE) && (state != ST_OUT);

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            mcand_p0    <= '0;
            mplier_p0   <= '0;
            prod_p0     <= '0;
            ext_p0      <= '0;
            mix_out     <= '0;
            mix_vld     <= 1'b0;
            sample_drop <= 1'b0;
`ifdef YM2413_AUDIO_OUT_FILTER_EN
            mix_p1      <= '0;
            acc_p2      <= '0;
`endif
        end else begin
            mix_vld     <= 1'b0;
            sample_drop <= sample_stb && busy;

            case (state)
                // Stage 0: capture operands
                ST_IDLE, ST_OUT: begin
                    if (sample_stb) begin
                        mcand_p0  <= PROD_W'(sample_in);
                        mplier_p0 <= fm_vol;
                        prod_p0   <= '0;
                        ext_p0    <= ext_in;
                        bit_cnt   <= '0;
                        state     <= ST_MUL;
                    end else begin
                        state     <= ST_IDLE;
                    end
                end

                // Shift-add multiply, one gain bit per cycle, LSB first
                ST_MUL: begin
                    if (mplier_p0[0]) begin
                        prod_p0 <= prod_p0 + mcand_p0;
                    end
                    mcand_p0  <= mcand_p0 << 1;
                    mplier_p0 <= mplier_p0 >> 1;
                    bit_cnt   <= bit_cnt + 2'd1;
                    if (bit_cnt == 2'd3) begin
                        state <= ST_SUM;
                    end
                end

                // Stage 1: scale and mix
                ST_SUM: begin
`ifdef YM2413_AUDIO_OUT_FILTER_EN
                    mix_p1  <= mix_sum(prod_p0, ext_p0);
                    state   <= ST_FILT;
`else
                    mix_out <= mix_sum(prod_p0, ext_p0);
                    mix_vld <= 1'b1;
                    state   <= ST_OUT;
`endif
                end

`ifdef YM2413_AUDIO_OUT_FILTER_EN
                // Stage 2: IIR low-pass, result published on entry to OUT
                ST_FILT: begin
                    acc_p2  <= acc_nxt;
                    mix_out <= MIX_W'(acc_nxt >> FILT_K);
                    mix_vld <= 1'b1;
                    state   <= ST_OUT;
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ym2413_ds_dac #(
        .DS_DIV (DS_DIV)
    ) u_ds_dac (
        .clk     (clk),
        .res_n   (res_n),
        .mix_out (mix_out),
        .dac_out (dac_out)
    );

endmodule

// File: tb/tb_ym2413_audio_out.sv
// tb_ym2413_audio_out
// Directed bench for ym2413_audio_out. Two instances share all inputs: one
// with DS_DIV=1 and one with DS_DIV=3. Expected values are hand-computed for
// both build variants (YM2413_AUDIO_OUT_FILTER_EN defined or not).
module tb_ym2413_audio_out;

`ifdef YM2413_AUDIO_OUT_FILTER_EN
    localparam int LAT        = 7;
    localparam int E_BASE_1   = 240;   // acc 960    -> 240
    localparam int E_BASE_2   = 420;   // acc 1680   -> 420
    localparam int E_FULL     = 991;   // acc 3966   -> 991
    localparam int E_EXT100   = 768;   // acc 3075   -> 768
    localparam int E_RST100   = 25;    // acc 100    -> 25
    localparam int E_DS_MIX   = 256;   // acc 1024   -> 256
    localparam int E_DS1_HIGH = 3;     // 48 cycles at 1/16
    localparam int E_DS1_RISE = 3;
    localparam int E_DS3_HIGH = 9;     // 144 cycles, 3 high per 48
    localparam int E_DS3_RISE = 3;
`else
    localparam int LAT        = 6;
    localparam int E_BASE_1   = 960;
    localparam int E_BASE_2   = 960;
    localparam int E_FULL     = 3966;  // 30705>>4 = 1919, + 2047
    localparam int E_EXT100   = 100;
    localparam int E_RST100   = 100;
    localparam int E_DS_MIX   = 1024;
    localparam int E_DS1_HIGH = 12;    // pattern 0001 over 48 cycles
    localparam int E_DS1_RISE = 12;
    localparam int E_DS3_HIGH = 36;    // 3-cycle holds, one per 12 cycles
    localparam int E_DS3_RISE = 12;
`endif

    logic        clk;
    logic        res_n;
    logic [10:0] sample_in;
    logic        sample_stb;
    logic [10:0] ext_in;
    logic [3:0]  fm_vol;
    logic [11:0] mix_out;
    logic        mix_vld;
    logic        sample_drop;
    logic        dac_out;
    logic [11:0] mix_out3;
    logic        mix_vld3;
    logic        sample_drop3;
    logic        dac_out3;

    int n_checks = 0;
    int n_errors = 0;

    ym2413_audio_out #(.FILT_K(2), .DS_DIV(1)) u_dut (
        .clk         (clk),
        .res_n       (res_n),
        .sample_in   (sample_in),
        .sample_stb  (sample_stb),
        .ext_in      (ext_in),
        .fm_vol      (fm_vol),
        .mix_out     (mix_out),
        .mix_vld     (mix_vld),
        .sample_drop (sample_drop),
        .dac_out     (dac_out)
    );

    ym2413_audio_out #(.FILT_K(2), .DS_DIV(3)) u_dut3 (
        .clk         (clk),
        .res_n       (res_n),
        .sample_in   (sample_in),
        .sample_stb  (sample_stb),
        .ext_in      (ext_in),
        .fm_vol      (fm_vol),
        .mix_out     (mix_out3),
        .mix_vld     (mix_vld3),
        .sample_drop (sample_drop3),
        .dac_out     (dac_out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the strobe during the current cycle (cycle 0) and returns in cycle 1.
    task automatic strobe(input logic [10:0] s, input logic [3:0] v, input logic [10:0] e);
        sample_in  = s;
        fm_vol     = v;
        ext_in     = e;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        res_n      = 1'b0;
        sample_stb = 1'b0;
        tick();
        check({tag, "_mix_out"},     int'(mix_out),     0);
        check({tag, "_mix_vld"},     int'(mix_vld),     0);
        check({tag, "_sample_drop"}, int'(sample_drop), 0);
        check({tag, "_dac_out"},     int'(dac_out),     0);
        check({tag, "_dac_out3"},    int'(dac_out3),    0);
        res_n = 1'b1;
    endtask

    task automatic run_sample(input string tag, input logic [10:0] s, input logic [3:0] v,
                              input logic [10:0] e, input int exp_mix);
        strobe(s, v, e);
        repeat (LAT - 2) tick();
        check({tag, "_vld_early"}, int'(mix_vld), 0);
        tick();
        check({tag, "_vld"}, int'(mix_vld), 1);
        check({tag, "_mix"}, int'(mix_out), exp_mix);
        tick();
        check({tag, "_vld_clear"}, int'(mix_vld), 0);
    endtask

    initial begin
        int vld_cnt;
        int vld_val;
        int hi1, rise1, hi3, rise3;
        logic prev1, prev3;

        res_n      = 1'b0;
        sample_stb = 1'b0;
        sample_in  = '0;
        ext_in     = '0;
        fm_vol     = '0;
        tick();
        apply_reset("rst0");

        // Basic gain path, twice to exercise the IIR memory
        run_sample("base1", 11'd1024, 4'd15, 11'd0, E_BASE_1);
        run_sample("base2", 11'd1024, 4'd15, 11'd0, E_BASE_2);

        // Full scale and zero gain
        apply_reset("rst1");
        run_sample("full",   11'd2047, 4'd15, 11'd2047, E_FULL);
        run_sample("ext100", 11'd2047, 4'd0,  11'd100,  E_EXT100);

        // Overrun: second strobe at cycle 3 is dropped
        apply_reset("rst2");
        strobe(11'd1024, 4'd15, 11'd0);
        tick();
        tick();
        sample_in  = 11'd2047;
        fm_vol     = 4'd15;
        ext_in     = 11'd2047;
        sample_stb = 1'b1;
        check("ovr_drop_c3", int'(sample_drop), 0);
        tick();
        sample_stb = 1'b0;
        check("ovr_drop_c4", int'(sample_drop), 1);
        tick();
        check("ovr_drop_c5", int'(sample_drop), 0);
        vld_cnt = 0;
        vld_val = -1;
        for (int c = 5; c <= LAT + 8; c++) begin
            if (mix_vld) begin
                vld_cnt++;
                vld_val = int'(mix_out);
            end
            tick();
        end
        check("ovr_vld_count", vld_cnt, 1);
        check("ovr_mix", vld_val, E_BASE_1);

        // Back-to-back: strobe in the output cycle is accepted
        apply_reset("rst3");
        strobe(11'd1024, 4'd15, 11'd0);
        repeat (LAT - 1) tick();
        check("b2b_vld1", int'(mix_vld), 1);
        check("b2b_mix1", int'(mix_out), E_BASE_1);
        strobe(11'd1024, 4'd15, 11'd0);
        check("b2b_no_drop", int'(sample_drop), 0);
        repeat (LAT - 1) tick();
        check("b2b_vld2", int'(mix_vld), 1);
        check("b2b_mix2", int'(mix_out), E_BASE_2);

        // Reset while a sample is in flight
        strobe(11'd1024, 4'd15, 11'd0);
        tick();
        res_n = 1'b0;
        tick();
        res_n = 1'b1;
        check("rmid_mix_out",     int'(mix_out),     0);
        check("rmid_mix_vld",     int'(mix_vld),     0);
        check("rmid_sample_drop", int'(sample_drop), 0);
        check("rmid_dac_out",     int'(dac_out),     0);
        vld_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (mix_vld) vld_cnt++;
            tick();
        end
        check("rmid_no_vld", vld_cnt, 0);
        run_sample("rmid_after", 11'd0, 4'd0, 11'd100, E_RST100);

        // Delta-sigma density with mix_out held constant
        apply_reset("rst4");
        strobe(11'd0, 4'd0, 11'd1024);
        repeat (LAT + 2) tick();
        check("ds_mix",  int'(mix_out),  E_DS_MIX);
        check("ds_mix3", int'(mix_out3), E_DS_MIX);
        hi1 = 0; rise1 = 0; hi3 = 0; rise3 = 0;
        prev1 = dac_out;
        prev3 = dac_out3;
        for (int c = 0; c < 144; c++) begin
            tick();
            if (c < 48) begin
                if (dac_out) hi1++;
                if (dac_out && !prev1) rise1++;
            end
            if (dac_out3) hi3++;
            if (dac_out3 && !prev3) rise3++;
            prev1 = dac_out;
            prev3 = dac_out3;
        end
        check("ds1_high", hi1,   E_DS1_HIGH);
        check("ds1_rise", rise1, E_DS1_RISE);
        check("ds3_high", hi3,   E_DS3_HIGH);
        check("ds3_rise", rise3, E_DS3_RISE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
